// File: rtl/chess_clock_ctrl_pkg.sv
// Shared types for the chess clock sequencer: FSM state encoding and side constants.
package chess_clock_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StArmed = 3'd2,
    StRunW  = 3'd3,
    StRunB  = 3'd4,
    StPause = 3'd5,
    StFlag  = 3'd6,
    StOver  = 3'd7
  } clock_state_t;

  localparam logic SIDE_WHITE = 1'b0;
  localparam logic SIDE_BLACK = 1'b1;

  function automatic clock_state_t run_state(input logic side);
    return (side == SIDE_BLACK) ? StRunB : StRunW;
  endfunction

endpackage

// File: rtl/switch_guard_timer.sv
// Reloadable down-counter that blanks move_done for a fixed window after a side switch.
module switch_guard_timer #(
  parameter int unsigned SWITCH_GUARD_CYC = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (SWITCH_GUARD_CYC > 0) ? $clog2(SWITCH_GUARD_CYC + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (reload) begin
      cnt_d = CntW'(SWITCH_GUARD_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock sequencer driving the white/black countdown counters.
// Optional pause support is enabled by defining CHESS_CLOCK_PAUSE_EN.
module chess_clock_ctrl
  import chess_clock_ctrl_pkg::*;
#(
  parameter int unsigned SWITCH_GUARD_CYC = 16,
  parameter int unsigned MOVE_NUM_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  new_game,
  input  logic [1:0]            mode_sel,
  input  logic                  move_done,
  input  logic                  pause_req,
  input  logic                  game_over_in,
  input  logic                  time_up_w,
  input  logic                  time_up_b,
  output logic [1:0]            mode_sel_q,
  output logic                  load,
  output logic                  start,
  output logic                  count_w,
  output logic                  count_b,
  output logic                  side_to_move,
  output logic                  flag_w,
  output logic                  flag_b,
  output logic [MOVE_NUM_W-1:0] move_num,
  output logic [2:0]            clk_state
);

  clock_state_t          state_q, state_d;
  logic                  side_q, side_d;
  logic                  flag_w_q, flag_w_d;
  logic                  flag_b_q, flag_b_d;
  logic [MOVE_NUM_W-1:0] move_num_q, move_num_d;
  logic [1:0]            mode_q, mode_d;
  logic                  load_q, start_q, count_w_q, count_b_q;
  logic                  guard_reload, guard_clear, guard_expired;

`ifdef CHESS_CLOCK_PAUSE_EN
  logic pause_hit;
  assign pause_hit = pause_req;
`else
  logic pause_hit;
  logic unused_pause_req;
  assign pause_hit        = 1'b0;
  assign unused_pause_req = pause_req;
`endif

  switch_guard_timer #(
    .SWITCH_GUARD_CYC(SWITCH_GUARD_CYC)
  ) u_guard (
    .clk    (clk),
    .reset_n(reset_n),
    .reload (guard_reload),
    .clear  (guard_clear),
    .expired(guard_expired)
  );

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    flag_w_d     = flag_w_q;
    flag_b_d     = flag_b_q;
    move_num_d   = move_num_q;
    mode_d       = mode_q;
    guard_reload = 1'b0;
    guard_clear  = 1'b0;

    if (new_game) begin
      state_d     = StLoad;
      mode_d      = mode_sel;
      move_num_d  = MOVE_NUM_W'(1);
      flag_w_d    = 1'b0;
      flag_b_d    = 1'b0;
      side_d      = SIDE_WHITE;
      guard_clear = 1'b1;
    end else begin
      unique case (state_q)
        StLoad:  state_d = StArmed;
        StArmed: begin
          if (game_over_in)   state_d = StOver;
          else if (move_done) state_d = StRunW;
        end
        StRunW: begin
          if (time_up_w) begin
            state_d  = StFlag;
            flag_w_d = 1'b1;
          end else if (game_over_in) begin
            state_d = StOver;
          end else if (pause_hit) begin
            state_d = StPause;
          end else if (move_done && guard_expired) begin
            state_d      = StRunB;
            side_d       = SIDE_BLACK;
            guard_reload = 1'b1;
          end
        end
        StRunB: begin
          if (time_up_b) begin
            state_d  = StFlag;
            flag_b_d = 1'b1;
          end else if (game_over_in) begin
            state_d = StOver;
          end else if (pause_hit) begin
            state_d = StPause;
          end else if (move_done && guard_expired) begin
            state_d      = StRunW;
            side_d       = SIDE_WHITE;
            guard_reload = 1'b1;
            if (move_num_q != '1) move_num_d = move_num_q + MOVE_NUM_W'(1);
          end
        end
`ifdef CHESS_CLOCK_PAUSE_EN
        StPause: begin
          // Resume with a cleared guard so the first move is not blanked.
          if (pause_req) begin
            state_d     = run_state(side_q);
            guard_clear = 1'b1;
          end else if (game_over_in) begin
            state_d = StOver;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      side_q     <= 1'b0;
      flag_w_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      move_num_q <= '0;
      mode_q     <= '0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      count_w_q  <= 1'b0;
      count_b_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      side_q     <= side_d;
      flag_w_q   <= flag_w_d;
      flag_b_q   <= flag_b_d;
      move_num_q <= move_num_d;
      mode_q     <= mode_d;
      // Strobes decoded from the next state so they align with the state register.
      load_q     <= (state_d == StLoad);
      start_q    <= (state_d != StIdle) && (state_d != StLoad);
      count_w_q  <= (state_d == StRunW);
      count_b_q  <= (state_d == StRunB);
    end
  end

  assign mode_sel_q   = mode_q;
  assign load         = load_q;
  assign start        = start_q;
  assign count_w      = count_w_q;
  assign count_b      = count_b_q;
  assign side_to_move = side_q;
  assign flag_w       = flag_w_q;
  assign flag_b       = flag_b_q;
  assign move_num     = move_num_q;
  assign clk_state    = state_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: directed plan then randomized pulses vs a move-level model.
module tb_chess_clock_ctrl;

  localparam int unsigned Guard = 16;
  localparam int unsigned MoveW = 10;
  localparam int MaxMoves = (1 << MoveW) - 1;
`ifdef CHESS_CLOCK_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  localparam int PIdle = 0, PLoad = 1, PArmed = 2, PRunW = 3, PRunB = 4, PPause = 5, PFlag = 6,
                 POver = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic new_game = 1'b0, move_done = 1'b0, pause_req = 1'b0, game_over_in = 1'b0;
  logic time_up_w = 1'b0, time_up_b = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [1:0] mode_sel_q;
  logic load, start, count_w, count_b, side_to_move, flag_w, flag_b;
  logic [MoveW-1:0] move_num;
  logic [2:0] clk_state;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: game phase, whose turn, move count, and time of last side switch.
  int m_ph, m_moves, last_sw, cyc;
  bit m_side, m_fw, m_fb;
  bit [1:0] m_mode;

  always #5 clk = ~clk;

  chess_clock_ctrl #(
    .SWITCH_GUARD_CYC(Guard),
    .MOVE_NUM_W      (MoveW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .new_game    (new_game),
    .mode_sel    (mode_sel),
    .move_done   (move_done),
    .pause_req   (pause_req),
    .game_over_in(game_over_in),
    .time_up_w   (time_up_w),
    .time_up_b   (time_up_b),
    .mode_sel_q  (mode_sel_q),
    .load        (load),
    .start       (start),
    .count_w     (count_w),
    .count_b     (count_b),
    .side_to_move(side_to_move),
    .flag_w      (flag_w),
    .flag_b      (flag_b),
    .move_num    (move_num),
    .clk_state   (clk_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("clk_state", 32'(clk_state), 32'(m_ph));
    chk("load", 32'(load), 32'(m_ph == PLoad));
    chk("start", 32'(start), 32'(m_ph >= PArmed));
    chk("count_w", 32'(count_w), 32'(m_ph == PRunW));
    chk("count_b", 32'(count_b), 32'(m_ph == PRunB));
    chk("side", 32'(side_to_move), 32'(m_side));
    chk("flag_w", 32'(flag_w), 32'(m_fw));
    chk("flag_b", 32'(flag_b), 32'(m_fb));
    chk("move_num", 32'(move_num), 32'(m_moves));
    chk("mode_sel_q", 32'(mode_sel_q), 32'(m_mode));
  endtask

  task automatic model_reset();
    m_ph = PIdle; m_moves = 0; m_side = 0; m_fw = 0; m_fb = 0; m_mode = 0; last_sw = -1000;
  endtask

  task automatic model_edge(input bit ng, input bit [1:0] ms, input bit md, input bit pr,
                            input bit go, input bit tuw, input bit tub);
    bit my_time_up;
    cyc++;
    if (ng) begin
      m_ph = PLoad; m_mode = ms; m_moves = 1; m_fw = 0; m_fb = 0; m_side = 0; last_sw = -1000;
    end else begin
      case (m_ph)
        PLoad:  m_ph = PArmed;
        PArmed: if (go) m_ph = POver; else if (md) m_ph = PRunW;
        PRunW, PRunB: begin
          my_time_up = m_side ? tub : tuw;
          if (my_time_up) begin
            m_ph = PFlag;
            if (m_side) m_fb = 1; else m_fw = 1;
          end else if (go) m_ph = POver;
          else if (pr && PauseEn) m_ph = PPause;
          else if (md && (cyc - last_sw > int'(Guard))) begin
            if (m_side && m_moves < MaxMoves) m_moves++;
            m_side = ~m_side;
            m_ph = m_side ? PRunB : PRunW;
            last_sw = cyc;
          end
        end
        PPause: begin
          if (pr) begin
            m_ph = m_side ? PRunB : PRunW;
            last_sw = -1000;
          end else if (go) m_ph = POver;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit ng = 0, input bit [1:0] ms = 0, input bit md = 0,
                      input bit pr = 0, input bit go = 0, input bit tuw = 0, input bit tub = 0);
    @(negedge clk);
    new_game = ng; mode_sel = ms; move_done = md; pause_req = pr;
    game_over_in = go; time_up_w = tuw; time_up_b = tub;
    @(posedge clk);
    model_edge(ng, ms, md, pr, go, tuw, tub);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // New game, first moves and guard behaviour.
    step(.ng(1), .ms(2));
    step();
    step(.md(1));
    idle(19);
    step(.md(1));
    idle(4);
    step(.md(1));
    idle(11);
    step(.md(1));
    // Flag beats a simultaneous move.
    idle(18);
    step(.md(1), .tuw(1));
    idle(2);
    step(.md(1));
    idle(20);
    step(.md(1));
    step(.ng(1), .ms(1));
    step();
    // Pause from black's turn, then game over.
    step(.md(1));
    idle(17);
    step(.md(1));
    idle(3);
    step(.pr(1));
    idle(2);
    step(.md(1));
    idle(2);
    step(.pr(1));
    idle(2);
    step(.go(1));
    idle(2);
    step(.md(1));

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      int r;
      bit ng, md, pr, go, tuw, tub;
      r   = int'($urandom_range(0, 99));
      md  = (r < 20);
      pr  = (r >= 20 && r < 26);
      go  = (r >= 26 && r < 28);
      tuw = ($urandom_range(0, 99) < 2);
      tub = ($urandom_range(0, 99) < 2);
      ng  = ($urandom_range(0, 99) < 2) ||
            ((m_ph == PIdle || m_ph == PFlag || m_ph == POver) && $urandom_range(0, 9) == 0);
      step(.ng(ng), .ms(2'($urandom_range(0, 3))), .md(md), .pr(pr), .go(go), .tuw(tuw),
           .tub(tub));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
